fp_argmax_stream: RTL and testbench
===================================

FP_ARGMAX_STREAM -- requirements
Module: fp_argmax_stream

Interface
REQ-001 Parameter VEC_LEN, default 8, number of IEEE-754 single-precision elements per reduction vector (legal range 2..256).
REQ-002 Parameter IDX_W, default $clog2(VEC_LEN), width of the index output.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  in_data holds an element.
REQ-006 in_ready  output  1  block accepts an element this cycle.
REQ-007 in_data  input  32  IEEE-754 single-precision element.
REQ-008 out_valid  output  1  reduction result available.
REQ-009 out_ready  input  1  consumer takes the result this cycle.
REQ-010 out_max  output  32  largest element of the vector.
REQ-011 out_idx  output  IDX_W  position (0-based) of out_max within the vector.
REQ-012 out_nan  output  1  present only with FP_ARGMAX_NAN_EN: at least one NaN seen in the vector.

Function
REQ-013 The FSM shall have exactly two states: ACCUM and DONE.
REQ-014 In ACCUM, in_ready shall be 1; in DONE, in_ready shall be 0.
REQ-015 An element shall be accepted on a cycle where in_valid && in_ready.
REQ-016 Element counter cnt (IDX_W bits) shall start at 0 and increment on each accept.
REQ-017 The accept at cnt==0 shall load best_val=in_data and best_idx=0 unconditionally.
REQ-018 An accept at cnt>0 shall replace best_val/best_idx with in_data/cnt only when in_data is strictly greater than best_val, i.e. NOT (best_val >= in_data).
REQ-019 Tie rule: on equal values the earliest index is kept.
REQ-020 Ordering: sign bit first, then 8-bit exponent, then 23-bit mantissa, using magnitude inversion for negatives.
REQ-021 Consequence of REQ-020: +0.0 (0x00000000) ranks strictly above -0.0 (0x80000000).
REQ-022 The accept at cnt==VEC_LEN-1 shall apply REQ-018 to that element, reset cnt to 0, and enter DONE.
REQ-023 out_valid shall rise the cycle after the last accept (1-cycle latency) and be registered.
REQ-024 In DONE, out_valid=1 and out_max/out_idx/out_nan shall be held stable until out_valid && out_ready.
REQ-025 Handshake completion in DONE shall return to ACCUM on the next cycle; no element shall be accepted on the completing cycle.
REQ-026 in_valid while in DONE shall be ignored (back-pressure via in_ready=0).
REQ-027 in_valid gaps in ACCUM shall not alter state.
REQ-028 out_valid shall not depend combinationally on out_ready.

Reset
REQ-029 Asserting rst at any time, including mid-vector or in DONE, shall force ACCUM, cnt=0, out_valid=0, out_max=0, out_idx=0, out_nan=0, discarding any partial vector.
REQ-030 The first element after rst deassertion shall be treated as index 0.

Configuration
REQ-031 Macro FP_ARGMAX_NAN_EN shall select NaN handling.
REQ-032 With FP_ARGMAX_NAN_EN defined:
- exponent 0xFF with nonzero mantissa is a NaN;
- a NaN never replaces best_val and sets a sticky nan flag, cleared at the start of each vector;
- a NaN at index 0 loads best_val but is replaced by the first non-NaN element;
- out_nan reports the flag;
- an all-NaN vector returns index 0.
REQ-033 Without FP_ARGMAX_NAN_EN, out_nan shall not exist and NaNs shall be ordered by raw bits per REQ-020.

Structure
REQ-034 Shared package fp_pkg shall hold:
- typedef fp32_t as a packed struct {sign, exp[7:0], man[22:0]};
- constants FP_EXP_MAX=8'hFF and FP_POS_ZERO=32'h0;
- enum argmax_state_t {ACCUM, DONE}.
REQ-035 The comparison shall be a purely combinational sub-module fp_ge (A >= B) instantiated once; all state stays in fp_argmax_stream.

Verification
REQ-036 VEC_LEN=8, inputs 1.0,3.0,2.0,3.0,-5.0,0.5,0.0,2.5 (0x3F800000, 0x40400000, ...) -> out_max=0x40400000, out_idx=1, out_valid 1 cycle after 8th accept.
REQ-037 All-negative vector -1.0,-0.5,-2.0,... -> out_max=0xBF000000 (-0.5), out_idx=1.
REQ-038 Vector of 0x80000000 at idx0 and 0x00000000 at idx5, others negative -> out_max=0x00000000, out_idx=5.
REQ-039 Hold out_ready=0 for 10 cycles in DONE with in_valid=1 -> outputs stable, in_ready=0, no element consumed; release -> next vector starts at idx 0.
REQ-040 rst pulse after 4 accepts, then full new vector -> result reflects only the new vector; outputs 0 during/after reset until done.
REQ-041 With FP_ARGMAX_NAN_EN: 0x7FC00000 at idx2 in vector of 1.0..8.0 -> out_max=0x41000000, out_idx=7, out_nan=1; next clean vector -> out_nan=0.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision types, constants and the argmax FSM state
// enum used by fp_argmax_stream and its comparator.
package fp_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } fp32_t;

  localparam logic [7:0]  FP_EXP_MAX  = 8'hFF;
  localparam logic [31:0] FP_POS_ZERO = 32'h0;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } argmax_state_t;

  function automatic logic fp_is_nan(input fp32_t v);
    return (v.exp == FP_EXP_MAX) && (v.man != 23'd0);
  endfunction

endpackage

// File: rtl/fp_ge.sv
// Combinational total-order comparison of two fp32 bit patterns: ge_o = (a_i >= b_i).
// Negatives are magnitude-inverted so -0.0 ranks just below +0.0.
module fp_ge
  import fp_pkg::*;
(
  input  fp32_t a_i,
  input  fp32_t b_i,
  output logic  ge_o
);

  logic [31:0] aBits;
  logic [31:0] bBits;
  logic [31:0] keyA;
  logic [31:0] keyB;

  // Map each pattern onto an unsigned key whose natural order matches float order.
  always_comb begin
    aBits = a_i;
    bBits = b_i;
    keyA  = a_i.sign ? ~aBits : {1'b1, aBits[30:0]};
    keyB  = b_i.sign ? ~bBits : {1'b1, bBits[30:0]};
    ge_o  = (keyA >= keyB);
  end

endmodule

// File: rtl/fp_argmax_stream.sv
// Streaming argmax over VEC_LEN fp32 elements with a registered result handshake.
// Optional NaN tracking and out_nan port are enabled by defining FP_ARGMAX_NAN_EN.
module fp_argmax_stream
  import fp_pkg::*;
#(
  parameter int VEC_LEN = 8,
  parameter int IDX_W   = $clog2(VEC_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_max,
  output logic [IDX_W-1:0] out_idx
`ifdef FP_ARGMAX_NAN_EN
  ,
  output logic             out_nan
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN - 1);

  argmax_state_t    state_q;
  logic [IDX_W-1:0] cnt_q;
  logic [31:0]      best_val_q;
  logic [31:0]      best_val_d;
  logic [IDX_W-1:0] best_idx_q;
  logic [IDX_W-1:0] best_idx_d;
  logic             out_valid_q;
  logic [31:0]      out_max_q;
  logic [IDX_W-1:0] out_idx_q;

  logic accept;
  logic firstElem;
  logic lastElem;
  logic bestGe;
  logic replace;

`ifdef FP_ARGMAX_NAN_EN
  logic nan_q;
  logic nan_d;
  logic best_nan_q;
  logic best_nan_d;
  logic out_nan_q;
  logic inNan;
`endif

  fp_ge u_fp_ge (
    .a_i  (best_val_q),
    .b_i  (in_data),
    .ge_o (bestGe)
  );

  assign in_ready  = (state_q == ACCUM);
  assign accept    = in_valid && in_ready;
  assign firstElem = (cnt_q == '0);
  assign lastElem  = (cnt_q == LAST_IDX);

  // Replacement only on strictly greater, so ties keep the earliest index.
  always_comb begin
    replace    = 1'b0;
    best_val_d = best_val_q;
    best_idx_d = best_idx_q;
`ifdef FP_ARGMAX_NAN_EN
    inNan      = fp_is_nan(in_data);
    nan_d      = firstElem ? inNan : (nan_q | inNan);
    best_nan_d = best_nan_q;
    replace    = firstElem || (!inNan && (best_nan_q || !bestGe));
    if (replace) begin
      best_nan_d = inNan;
    end
`else
    replace    = firstElem || !bestGe;
`endif
    if (replace) begin
      best_val_d = in_data;
      best_idx_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACCUM;
      cnt_q       <= '0;
      best_val_q  <= FP_POS_ZERO;
      best_idx_q  <= '0;
      out_valid_q <= 1'b0;
      out_max_q   <= FP_POS_ZERO;
      out_idx_q   <= '0;
`ifdef FP_ARGMAX_NAN_EN
      nan_q       <= 1'b0;
      best_nan_q  <= 1'b0;
      out_nan_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ACCUM: begin
          if (accept) begin
            best_val_q <= best_val_d;
            best_idx_q <= best_idx_d;
`ifdef FP_ARGMAX_NAN_EN
            nan_q      <= nan_d;
            best_nan_q <= best_nan_d;
`endif
            if (lastElem) begin
              cnt_q       <= '0;
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              out_max_q   <= best_val_d;
              out_idx_q   <= best_idx_d;
`ifdef FP_ARGMAX_NAN_EN
              out_nan_q   <= nan_d;
`endif
            end else begin
              cnt_q <= cnt_q + IDX_W'(1);
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ACCUM;
          end
        end
        default: begin
          state_q <= ACCUM;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_max   = out_max_q;
  assign out_idx   = out_idx_q;
`ifdef FP_ARGMAX_NAN_EN
  assign out_nan   = out_nan_q;
`endif

endmodule

// File: tb/tb_fp_argmax_stream.sv
// Self-checking bench for fp_argmax_stream: directed vectors, back-pressure, mid-vector
// reset and randomized vectors against a rank-based argmax model (NaN cases with FP_ARGMAX_NAN_EN).
module tb_fp_argmax_stream;

   localparam int VEC_LEN = 8;
   localparam int IDX_W   = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_data;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_max;
   logic [IDX_W-1:0] out_idx;
`ifdef FP_ARGMAX_NAN_EN
   logic             out_nan;
`endif

   int checks   = 0;
   int failures = 0;

   logic [31:0] stim [VEC_LEN];
   logic [31:0] expMax;
   int          expIdx;
   bit          expNan;

   fp_argmax_stream #(.VEC_LEN(VEC_LEN), .IDX_W(IDX_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_max   (out_max),
      .out_idx   (out_idx)
`ifdef FP_ARGMAX_NAN_EN
      ,
      .out_nan   (out_nan)
`endif
   );

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   // Rank of a float pattern as a plain signed integer: bigger rank means bigger value,
   // and -0.0 lands one step below +0.0.
   function automatic longint rankOf(input logic [31:0] b);
      longint mag;
      mag = longint'(b[30:0]);
      return b[31] ? (-mag - 1) : mag;
   endfunction

   function automatic bit isNan(input logic [31:0] b);
      return (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
   endfunction

   // Reference argmax over the current stim array, first occurrence wins on ties.
   task automatic computeRef();
      int bestI;
      bit skip;
      bestI  = -1;
      expNan = 1'b0;
      for (int i = 0; i < VEC_LEN; i++) begin
`ifdef FP_ARGMAX_NAN_EN
         skip = isNan(stim[i]);
`else
         skip = 1'b0;
`endif
         if (skip) expNan = 1'b1;
         else if (bestI < 0 || rankOf(stim[i]) > rankOf(stim[bestI])) bestI = i;
      end
      if (bestI < 0) bestI = 0;
      expIdx = bestI;
      expMax = stim[bestI];
   endtask

   function automatic logic [31:0] randVal();
      logic [31:0] pool [6];
      logic [31:0] v;
      pool[0] = 32'h3F800000; pool[1] = 32'hBF800000; pool[2] = 32'h00000000;
      pool[3] = 32'h80000000; pool[4] = 32'h40000000; pool[5] = 32'hC0000000;
      case ($urandom_range(0, 3))
         0:       v = pool[$urandom_range(0, 5)];
         1:       v = $urandom;
         default: v = {1'($urandom_range(0, 1)), 8'($urandom_range(120, 135)), 23'($urandom)};
      endcase
      return v;
   endfunction

   // Feed stim[0..VEC_LEN-1] with optional idle gaps; returns #1 after the last accept edge.
   task automatic applyStimulus(input int maxGap);
      int gap;
      int waitCnt;
      for (int i = 0; i < VEC_LEN; i++) begin
         gap = (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0;
         in_valid = 1'b0;
         repeat (gap) begin
            @(posedge clk);
            #1;
         end
         in_valid = 1'b1;
         in_data  = stim[i];
         waitCnt  = 0;
         while (in_ready !== 1'b1 && waitCnt < 50) begin
            @(posedge clk);
            #1;
            waitCnt++;
         end
         if (waitCnt >= 50) begin
            checks++;
            failures++;
            $display("[TB] FAIL accept_timeout: in_ready=%b required 1 within 50 cycles", in_ready);
            in_valid = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic releaseResult(input int delay);
      repeat (delay) begin
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = 32'h0;
      out_ready = 1'b0;
      #12;
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid: got %b required 0", out_valid); end
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready: got %b required 1", in_ready); end
      checks++;
      if (out_max !== 32'h0) begin failures++; $display("[TB] FAIL reset_out_max: got %h required 00000000", out_max); end
      checks++;
      if (out_idx !== '0) begin failures++; $display("[TB] FAIL reset_out_idx: got %0d required 0", out_idx); end
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_directed();
      logic [31:0] tbl [3][VEC_LEN];
      logic [31:0] wantMax [3];
      int          wantIdx [3];
      tbl[0] = '{32'h3F800000, 32'h40400000, 32'h40000000, 32'h40400000,
                 32'hC0A00000, 32'h3F000000, 32'h00000000, 32'h40200000};
      tbl[1] = '{32'hBF800000, 32'hBF000000, 32'hC0000000, 32'hC0400000,
                 32'hC0800000, 32'hBFC00000, 32'hBF400000, 32'hC1000000};
      tbl[2] = '{32'h80000000, 32'hBF800000, 32'hC0000000, 32'hBF000000,
                 32'hC0400000, 32'h00000000, 32'hBF400000, 32'hC1000000};
      wantMax = '{32'h40400000, 32'hBF000000, 32'h00000000};
      wantIdx = '{1, 1, 5};
      for (int v = 0; v < 3; v++) begin
         for (int i = 0; i < VEC_LEN; i++) stim[i] = tbl[v][i];
         applyStimulus(0);
         checks++;
         if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL directed%0d_latency: out_valid=%b required 1", v, out_valid); end
         checks++;
         if (out_max !== wantMax[v]) begin failures++; $display("[TB] FAIL directed%0d_max: got %h required %h", v, out_max, wantMax[v]); end
         checks++;
         if (out_idx !== IDX_W'(wantIdx[v])) begin failures++; $display("[TB] FAIL directed%0d_idx: got %0d required %0d", v, out_idx, wantIdx[v]); end
         releaseResult(0);
         checks++;
         if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL directed%0d_release: out_valid=%b required 0", v, out_valid); end
      end
   endtask

   task automatic test_backpressure();
      stim = '{32'h3F800000, 32'h40400000, 32'h40000000, 32'h40400000,
               32'hC0A00000, 32'h3F000000, 32'h00000000, 32'h40200000};
      applyStimulus(0);
      in_valid = 1'b1;
      in_data  = 32'h7F000000;
      repeat (10) begin
         @(posedge clk);
         #1;
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_max !== 32'h40400000 || out_idx !== 3'd1) begin
            failures++;
            $display("[TB] FAIL hold_stable: valid=%b ready=%b max=%h idx=%0d required 1 0 40400000 1",
                     out_valid, in_ready, out_max, out_idx);
         end
      end
      in_valid = 1'b0;
      releaseResult(0);
      stim = '{32'h42C80000, 32'h3F800000, 32'h40000000, 32'h40400000,
               32'h40800000, 32'h40A00000, 32'h40C00000, 32'h40E00000};
      applyStimulus(0);
      checks++;
      if (out_max !== 32'h42C80000) begin failures++; $display("[TB] FAIL after_hold_max: got %h required 42c80000", out_max); end
      checks++;
      if (out_idx !== 3'd0) begin failures++; $display("[TB] FAIL after_hold_idx: got %0d required 0", out_idx); end
      releaseResult(1);
   endtask

   task automatic test_reset_mid();
      in_valid = 1'b1;
      in_data  = 32'h7F000000;
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      rst = 1'b1;
      #2;
      checks++;
      if (out_valid !== 1'b0 || out_max !== 32'h0 || out_idx !== '0 || in_ready !== 1'b1) begin
         failures++;
         $display("[TB] FAIL mid_reset_clear: valid=%b max=%h idx=%0d ready=%b required 0 00000000 0 1",
                  out_valid, out_max, out_idx, in_ready);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < VEC_LEN; i++) stim[i] = randVal();
      stim[3] = 32'hC2000000;
      computeRef();
      applyStimulus(1);
      checks++;
      if (out_max !== expMax || out_idx !== IDX_W'(expIdx)) begin
         failures++;
         $display("[TB] FAIL post_reset_result: max=%h idx=%0d required %h %0d", out_max, out_idx, expMax, expIdx);
      end
      releaseResult(0);
   endtask

   task automatic test_random();
      for (int n = 0; n < 25; n++) begin
         for (int i = 0; i < VEC_LEN; i++) stim[i] = randVal();
         computeRef();
         applyStimulus(2);
         checks++;
         if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL random%0d_valid: got %b required 1", n, out_valid); end
         checks++;
         if (out_max !== expMax || out_idx !== IDX_W'(expIdx)) begin
            failures++;
            $display("[TB] FAIL random%0d_result: max=%h idx=%0d required %h %0d", n, out_max, out_idx, expMax, expIdx);
         end
`ifdef FP_ARGMAX_NAN_EN
         checks++;
         if (out_nan !== expNan) begin failures++; $display("[TB] FAIL random%0d_nan: got %b required %b", n, out_nan, expNan); end
`endif
         releaseResult($urandom_range(0, 3));
      end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      for (int n = 0; n < 3; n++) begin
         for (int i = 0; i < VEC_LEN; i++) stim[i] = randVal();
         computeRef();
         applyStimulus(0);
         checks++;
         if (out_valid !== 1'b1 || out_max !== expMax || out_idx !== IDX_W'(expIdx)) begin
            failures++;
            $display("[TB] FAIL b2b%0d_result: valid=%b max=%h idx=%0d required 1 %h %0d",
                     n, out_valid, out_max, out_idx, expMax, expIdx);
         end
      end
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_release: out_valid=%b required 0", out_valid); end
   endtask

`ifdef FP_ARGMAX_NAN_EN
   task automatic test_nan();
      stim = '{32'h3F800000, 32'h40000000, 32'h7FC00000, 32'h40800000,
               32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
      applyStimulus(0);
      checks++;
      if (out_max !== 32'h41000000 || out_idx !== 3'd7 || out_nan !== 1'b1) begin
         failures++;
         $display("[TB] FAIL nan_mid: max=%h idx=%0d nan=%b required 41000000 7 1", out_max, out_idx, out_nan);
      end
      releaseResult(0);
      stim = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
               32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h3F000000};
      applyStimulus(0);
      checks++;
      if (out_max !== 32'h40E00000 || out_idx !== 3'd6 || out_nan !== 1'b0) begin
         failures++;
         $display("[TB] FAIL nan_clean: max=%h idx=%0d nan=%b required 40e00000 6 0", out_max, out_idx, out_nan);
      end
      releaseResult(0);
      stim = '{32'h7FC00000, 32'hC0000000, 32'h7F800001, 32'hBF800000,
               32'hC0400000, 32'hFFC00000, 32'hC1000000, 32'hC0800000};
      applyStimulus(0);
      checks++;
      if (out_max !== 32'hBF800000 || out_idx !== 3'd3 || out_nan !== 1'b1) begin
         failures++;
         $display("[TB] FAIL nan_idx0: max=%h idx=%0d nan=%b required bf800000 3 1", out_max, out_idx, out_nan);
      end
      releaseResult(0);
      for (int i = 0; i < VEC_LEN; i++) stim[i] = 32'h7FC00000 | 32'(i);
      applyStimulus(0);
      checks++;
      if (out_max !== 32'h7FC00000 || out_idx !== 3'd0 || out_nan !== 1'b1) begin
         failures++;
         $display("[TB] FAIL nan_all: max=%h idx=%0d nan=%b required 7fc00000 0 1", out_max, out_idx, out_nan);
      end
      releaseResult(0);
   endtask
`endif

   // Run every scenario in order, then print the single summary line.
   initial begin
      $display("[TB] starting fp_argmax_stream bench");
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_mid();
      test_random();
      test_back_to_back();
`ifdef FP_ARGMAX_NAN_EN
      test_nan();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
